// File: rtl/l2trans_pkg.sv
// l2trans_pkg: shared bus definitions for the L2 transaction unit.
//   - bus_cmd_e    : 3-bit system bus command encodings
//   - HDR_*        : bit offsets of the packet header fields
//   - buf_state_e  : line buffer occupancy state
//   - tx_state_e   : transmit serializer state
//   - build_header : assembles a header flit from its fields
package l2trans_pkg;

    localparam int BEATS_PER_LINE = 8;
    localparam int BEAT_IDX_W     = 3;

    typedef enum logic [2:0] {
        CMD_BUSRD     = 3'd0,
        CMD_BUSRDX    = 3'd1,
        CMD_UPGRADE   = 3'd2,
        CMD_FLUSH     = 3'd3,
        CMD_SNOOPRESP = 3'd4
    } bus_cmd_e;

    localparam int HDR_NODE_LSB    = 62;
    localparam int HDR_CMD_LSB     = 59;
    localparam int HDR_NOINV_BIT   = 58;
    localparam int HDR_RESP_BIT    = 57;
    localparam int HDR_TAG_LSB     = 52;
    localparam int HDR_ADDR_LSB    = 26;
    localparam int HDR_HASDATA_BIT = 0;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_FILL  = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_e;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_HDR  = 2'd1,
        TX_DATA = 2'd2
    } tx_state_e;

    // Header flit: unused bits [25:1] stay zero.
    function automatic logic [63:0] build_header(
        input logic [1:0]  node,
        input logic [2:0]  cmd,
        input logic        noinv,
        input logic        resp,
        input logic [4:0]  tag,
        input logic [25:0] addr,
        input logic        has_data
    );
        logic [63:0] h;
        h = 64'd0;
        h[HDR_NODE_LSB +: 2]  = node;
        h[HDR_CMD_LSB +: 3]   = cmd;
        h[HDR_NOINV_BIT]      = noinv;
        h[HDR_RESP_BIT]       = resp;
        h[HDR_TAG_LSB +: 5]   = tag;
        h[HDR_ADDR_LSB +: 26] = addr;
        h[HDR_HASDATA_BIT]    = has_data;
        return h;
    endfunction

endpackage

// File: rtl/l2trans_linebuf.sv
// l2trans_linebuf: one 8x64 line buffer with fill counter and occupancy state.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   beat_valid_i    incoming beat valid (first beat honoured only when EMPTY)
//   single_i        first beat completes the transaction (no data stored)
//   beat_data_i     beat payload
//   meta_i/meta_o   per-transaction fields captured on the first beat
//   release_i       packet fully transmitted, return to EMPTY
//   rd_idx_i        read index, rd_data_o is the entry at that index
//   ready_o         buffer EMPTY, full_o buffer FULL, empty_o buffer EMPTY
module l2trans_linebuf
    import l2trans_pkg::*;
#(
    parameter int META_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_valid_i,
    input  logic              single_i,
    input  logic [63:0]       beat_data_i,
    input  logic [META_W-1:0] meta_i,
    input  logic              release_i,
    input  logic [2:0]        rd_idx_i,
    output logic              ready_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [META_W-1:0] meta_o,
    output logic [63:0]       rd_data_o
);

    buf_state_e              state_q, state_d;
    logic [BEAT_IDX_W-1:0]   cnt_q, cnt_d;
    logic                    wr_en_s;
    logic                    meta_en_s;
    logic [63:0]             mem_q [BEATS_PER_LINE];
    logic [META_W-1:0]       meta_q;

    // Occupancy state and fill counter next-state; beats offered while FULL are ignored.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_en_s   = 1'b0;
        meta_en_s = 1'b0;
        case (state_q)
            BUF_EMPTY: begin
                if (beat_valid_i) begin
                    meta_en_s = 1'b1;
                    if (single_i) begin
                        state_d = BUF_FULL;
                    end else begin
                        wr_en_s = 1'b1;
                        cnt_d   = 3'd1;
                        state_d = BUF_FILL;
                    end
                end else begin
                    state_d = BUF_EMPTY;
                end
            end
            BUF_FILL: begin
                if (beat_valid_i) begin
                    wr_en_s = 1'b1;
                    cnt_d   = cnt_q + 3'd1;   // wraps 7 -> 0 on the final beat
                    if (cnt_q == 3'd7) begin
                        state_d = BUF_FULL;
                    end else begin
                        state_d = BUF_FILL;
                    end
                end else begin
                    state_d = BUF_FILL;
                end
            end
            BUF_FULL: begin
                if (release_i) begin
                    state_d = BUF_EMPTY;
                end else begin
                    state_d = BUF_FULL;
                end
            end
            default: begin
                state_d = BUF_EMPTY;
                cnt_d   = 3'd0;
            end
        endcase
    end

    // Occupancy state and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BUF_EMPTY;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Line storage and captured fields; contents survive reset by design.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_q[cnt_q] <= beat_data_i;
        end
        if (meta_en_s) begin
            meta_q <= meta_i;
        end
    end

    assign ready_o   = (state_q == BUF_EMPTY);
    assign empty_o   = (state_q == BUF_EMPTY);
    assign full_o    = (state_q == BUF_FULL);
    assign meta_o    = meta_q;
    assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/l2trans_tx.sv
// l2trans_tx: transmit half of the L2 transaction unit.
// Captures l2data request and snoop-data transactions into two line buffers
// and serializes them as header(+8 data) packets onto the bus transmit port.
// Snoop responses win over requests when both are ready to go.
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   l2data_req_*                 request stream in (cmd/noinv/addr/data)
//   l2trans_l2data_req_ready     request stream may start a transaction
//   l2data_snoop_*               snoop-data stream in (tag/addr/data)
//   l2trans_l2data_snoop_ready   snoop stream may start a response
//   bus_tx_valid/data/last/ready bus transmit flit port (outputs registered)
//   l2trans_tx_idle              both buffers empty and no packet in flight
module l2trans_tx
    import l2trans_pkg::*;
#(
    parameter logic [1:0] NODE_ID = 2'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        l2data_req_valid,
    input  logic        l2data_req_noinv,
    input  logic [2:0]  l2data_req_cmd,
    input  logic [25:0] l2data_req_addr,
    input  logic [63:0] l2data_req_data,
    output logic        l2trans_l2data_req_ready,
    input  logic        l2data_snoop_valid,
    input  logic [4:0]  l2data_snoop_tag,
    input  logic [25:0] l2data_snoop_addr,
    input  logic [63:0] l2data_snoop_data,
    output logic        l2trans_l2data_snoop_ready,
    output logic        bus_tx_valid,
    output logic [63:0] bus_tx_data,
    output logic        bus_tx_last,
    input  logic        bus_tx_ready,
    output logic        l2trans_tx_idle
);

    tx_state_e   tx_state_q, tx_state_d;
    logic        sel_snp_q, sel_snp_d;
    logic [2:0]  idx_q, idx_d;
    logic        valid_q, valid_d;
    logic [63:0] data_q, data_d;
    logic        last_q, last_d;

    logic        req_full_s, req_empty_s, snp_full_s, snp_empty_s;
    logic        req_release_s, snp_release_s, release_s;
    logic [29:0] req_meta_s;   // {cmd, noinv, addr}
    logic [30:0] snp_meta_s;   // {tag, addr}
    logic [63:0] req_rd_s, snp_rd_s, sel_rd_s;
    logic [2:0]  rd_idx_s;
    logic        req_has_data_s;
    logic [63:0] req_hdr_s, snp_hdr_s;

    l2trans_linebuf #(.META_W(30)) u_req_buf (
        .clk          (clk),
        .rst          (rst),
        .beat_valid_i (l2data_req_valid),
        .single_i     (l2data_req_cmd != CMD_FLUSH),
        .beat_data_i  (l2data_req_data),
        .meta_i       ({l2data_req_cmd, l2data_req_noinv, l2data_req_addr}),
        .release_i    (req_release_s),
        .rd_idx_i     (rd_idx_s),
        .ready_o      (l2trans_l2data_req_ready),
        .full_o       (req_full_s),
        .empty_o      (req_empty_s),
        .meta_o       (req_meta_s),
        .rd_data_o    (req_rd_s)
    );

    l2trans_linebuf #(.META_W(31)) u_snp_buf (
        .clk          (clk),
        .rst          (rst),
        .beat_valid_i (l2data_snoop_valid),
        .single_i     (1'b0),
        .beat_data_i  (l2data_snoop_data),
        .meta_i       ({l2data_snoop_tag, l2data_snoop_addr}),
        .release_i    (snp_release_s),
        .rd_idx_i     (rd_idx_s),
        .ready_o      (l2trans_l2data_snoop_ready),
        .full_o       (snp_full_s),
        .empty_o      (snp_empty_s),
        .meta_o       (snp_meta_s),
        .rd_data_o    (snp_rd_s)
    );

    assign req_has_data_s = (req_meta_s[29:27] == CMD_FLUSH);
    assign req_hdr_s = build_header(NODE_ID, req_meta_s[29:27], req_meta_s[26], 1'b0,
                                    5'd0, req_meta_s[25:0], req_has_data_s);
    assign snp_hdr_s = build_header(NODE_ID, CMD_SNOOPRESP, 1'b0, 1'b1,
                                    snp_meta_s[30:26], snp_meta_s[25:0], 1'b1);

    // The output register is loaded one flit ahead, so read the entry that follows idx_q.
    assign rd_idx_s = (tx_state_q == TX_DATA) ? (idx_q + 3'd1) : 3'd0;
    assign sel_rd_s = sel_snp_q ? snp_rd_s : req_rd_s;

    assign req_release_s = release_s & ~sel_snp_q;
    assign snp_release_s = release_s & sel_snp_q;

    // Transmit FSM next-state and registered flit outputs; everything holds while ready is low.
    always_comb begin
        tx_state_d = tx_state_q;
        sel_snp_d  = sel_snp_q;
        idx_d      = idx_q;
        valid_d    = valid_q;
        data_d     = data_q;
        last_d     = last_q;
        release_s  = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                if (snp_full_s) begin
                    sel_snp_d  = 1'b1;
                    tx_state_d = TX_HDR;
                    valid_d    = 1'b1;
                    data_d     = snp_hdr_s;
                    last_d     = 1'b0;
                end else if (req_full_s) begin
                    sel_snp_d  = 1'b0;
                    tx_state_d = TX_HDR;
                    valid_d    = 1'b1;
                    data_d     = req_hdr_s;
                    last_d     = ~req_has_data_s;
                end else begin
                    tx_state_d = TX_IDLE;
                end
            end
            TX_HDR: begin
                if (bus_tx_ready) begin
                    if (data_q[HDR_HASDATA_BIT]) begin
                        tx_state_d = TX_DATA;
                        idx_d      = 3'd0;
                        data_d     = sel_rd_s;
                        last_d     = 1'b0;
                    end else begin
                        release_s  = 1'b1;
                        tx_state_d = TX_IDLE;
                        valid_d    = 1'b0;
                        data_d     = 64'd0;
                        last_d     = 1'b0;
                    end
                end else begin
                    tx_state_d = TX_HDR;
                end
            end
            TX_DATA: begin
                if (bus_tx_ready) begin
                    if (idx_q == 3'd7) begin
                        release_s  = 1'b1;
                        tx_state_d = TX_IDLE;
                        valid_d    = 1'b0;
                        data_d     = 64'd0;
                        last_d     = 1'b0;
                    end else begin
                        idx_d  = idx_q + 3'd1;
                        data_d = sel_rd_s;
                        last_d = (idx_q == 3'd6);
                    end
                end else begin
                    tx_state_d = TX_DATA;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                valid_d    = 1'b0;
                data_d     = 64'd0;
                last_d     = 1'b0;
            end
        endcase
    end

    // Transmit FSM and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            sel_snp_q  <= 1'b0;
            idx_q      <= 3'd0;
            valid_q    <= 1'b0;
            data_q     <= 64'd0;
            last_q     <= 1'b0;
        end else begin
            tx_state_q <= tx_state_d;
            sel_snp_q  <= sel_snp_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            data_q     <= data_d;
            last_q     <= last_d;
        end
    end

    assign bus_tx_valid    = valid_q;
    assign bus_tx_data     = data_q;
    assign bus_tx_last     = last_q;
    assign l2trans_tx_idle = req_empty_s & snp_empty_s & (tx_state_q == TX_IDLE);

endmodule

// File: tb/tb_l2trans_tx.sv
// tb_l2trans_tx: randomized scoreboard bench for l2trans_tx.
// Drivers push the expected flits of each transaction into a per-stream queue;
// a negedge monitor pops and compares every accepted flit and tracks the
// expected ready/idle behaviour at transaction level.
module tb_l2trans_tx;
    import l2trans_pkg::*;

    localparam logic [1:0] NODE = 2'd2;

    logic        clk, rst;
    logic        l2data_req_valid, l2data_req_noinv;
    logic [2:0]  l2data_req_cmd;
    logic [25:0] l2data_req_addr;
    logic [63:0] l2data_req_data;
    logic        l2trans_l2data_req_ready;
    logic        l2data_snoop_valid;
    logic [4:0]  l2data_snoop_tag;
    logic [25:0] l2data_snoop_addr;
    logic [63:0] l2data_snoop_data;
    logic        l2trans_l2data_snoop_ready;
    logic        bus_tx_valid, bus_tx_last, bus_tx_ready;
    logic [63:0] bus_tx_data;
    logic        l2trans_tx_idle;

    l2trans_tx #(.NODE_ID(NODE)) dut (
        .clk                        (clk),
        .rst                        (rst),
        .l2data_req_valid           (l2data_req_valid),
        .l2data_req_noinv           (l2data_req_noinv),
        .l2data_req_cmd             (l2data_req_cmd),
        .l2data_req_addr            (l2data_req_addr),
        .l2data_req_data            (l2data_req_data),
        .l2trans_l2data_req_ready   (l2trans_l2data_req_ready),
        .l2data_snoop_valid         (l2data_snoop_valid),
        .l2data_snoop_tag           (l2data_snoop_tag),
        .l2data_snoop_addr          (l2data_snoop_addr),
        .l2data_snoop_data          (l2data_snoop_data),
        .l2trans_l2data_snoop_ready (l2trans_l2data_snoop_ready),
        .bus_tx_valid               (bus_tx_valid),
        .bus_tx_data                (bus_tx_data),
        .bus_tx_last                (bus_tx_last),
        .bus_tx_ready               (bus_tx_ready),
        .l2trans_tx_idle            (l2trans_tx_idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected flits per stream: {last, data}
    logic [64:0] exp_req_q[$];
    logic [64:0] exp_snp_q[$];
    logic        order_log[$];   // resp bit of each packet header, in send order

    logic [63:0] req_data_a [8];
    logic [63:0] snp_data_a [8];

    bit          rdy_rand = 1'b0;

    // Monitor state
    bit          busy_req = 1'b0, busy_snp = 1'b0;
    bit          in_pkt = 1'b0, cur_snp = 1'b0;
    bit          stall_prev = 1'b0, lastacc_prev = 1'b0;
    int          rem = 0;
    logic [64:0] prev_flit;

    task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk_hdr(input logic [2:0] cmd, input logic noinv,
                                           input logic resp, input logic [4:0] tag,
                                           input logic [25:0] addr, input logic hd);
        return {NODE, cmd, noinv, resp, tag, addr, 25'd0, hd};
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, bus_tx_valid, 1'b0);
        chk({tag, "_last"}, bus_tx_last, 1'b0);
        chk({tag, "_data"}, bus_tx_data, 64'd0);
        chk({tag, "_req_ready"}, l2trans_l2data_req_ready, 1'b1);
        chk({tag, "_snp_ready"}, l2trans_l2data_snoop_ready, 1'b1);
        chk({tag, "_idle"}, l2trans_tx_idle, 1'b1);
    endtask

    // Called and returns at posedge+1.
    task automatic drive_req(input logic [2:0] cmd, input logic noinv,
                             input logic [25:0] addr, input int max_gap);
        logic hd;
        int   n;
        int   t;
        hd = (cmd == CMD_FLUSH);
        n  = hd ? 8 : 1;
        t  = 0;
        exp_req_q.push_back({~hd, mk_hdr(cmd, noinv, 1'b0, 5'd0, addr, hd)});
        if (hd) begin
            for (int i = 0; i < 8; i++) exp_req_q.push_back({(i == 7), req_data_a[i]});
        end
        while (!l2trans_l2data_req_ready && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        chk("req_ready_timeout", (t >= 1000), 1'b0);
        for (int i = 0; i < n; i++) begin
            l2data_req_valid = 1'b1;
            l2data_req_cmd   = cmd;
            l2data_req_noinv = noinv;
            l2data_req_addr  = addr;
            l2data_req_data  = req_data_a[i];
            @(posedge clk); #1;
            l2data_req_valid = 1'b0;
            l2data_req_data  = {$urandom, $urandom};
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic drive_snp(input logic [4:0] tag, input logic [25:0] addr, input int max_gap);
        int t;
        t = 0;
        exp_snp_q.push_back({1'b0, mk_hdr(CMD_SNOOPRESP, 1'b0, 1'b1, tag, addr, 1'b1)});
        for (int i = 0; i < 8; i++) exp_snp_q.push_back({(i == 7), snp_data_a[i]});
        while (!l2trans_l2data_snoop_ready && t < 1000) begin
            @(posedge clk); #1; t++;
        end
        chk("snp_ready_timeout", (t >= 1000), 1'b0);
        for (int i = 0; i < 8; i++) begin
            l2data_snoop_valid = 1'b1;
            l2data_snoop_tag   = tag;
            l2data_snoop_addr  = addr;
            l2data_snoop_data  = snp_data_a[i];
            @(posedge clk); #1;
            l2data_snoop_valid = 1'b0;
            l2data_snoop_data  = {$urandom, $urandom};
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((exp_req_q.size() != 0 || exp_snp_q.size() != 0 || !l2trans_tx_idle) && t < budget) begin
            @(posedge clk); #1; t++;
        end
        chk("drain_timeout", (t >= budget), 1'b0);
    endtask

    task automatic wait_flit(input logic [63:0] val, input string name);
        int t;
        t = 0;
        while (!(bus_tx_valid && bus_tx_data == val) && t < 300) begin
            @(posedge clk); #1; t++;
        end
        chk(name, (t >= 300), 1'b0);
    endtask

    // Bus backpressure generator for the random phase.
    always @(posedge clk) begin
        #1;
        if (rdy_rand) bus_tx_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: per-cycle ready/idle expectations, hold and spacing rules, flit scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            while (rem > 0) begin
                if (cur_snp && exp_snp_q.size() > 0) void'(exp_snp_q.pop_front());
                else if (!cur_snp && exp_req_q.size() > 0) void'(exp_req_q.pop_front());
                rem--;
            end
            rem = 0; in_pkt = 1'b0;
            busy_req = 1'b0; busy_snp = 1'b0;
            stall_prev = 1'b0; lastacc_prev = 1'b0;
        end else begin
            chk("req_ready", l2trans_l2data_req_ready, !busy_req);
            chk("snp_ready", l2trans_l2data_snoop_ready, !busy_snp);
            chk("idle", l2trans_tx_idle, !busy_req && !busy_snp);
            if (stall_prev) begin
                chk("hold_valid", bus_tx_valid, 1'b1);
                chk("hold_flit", {bus_tx_last, bus_tx_data}, prev_flit);
            end
            if (lastacc_prev) chk("gap_valid", bus_tx_valid, 1'b0);
            stall_prev   = bus_tx_valid && !bus_tx_ready;
            prev_flit    = {bus_tx_last, bus_tx_data};
            lastacc_prev = 1'b0;
            if (l2data_req_valid && !busy_req) busy_req = 1'b1;
            if (l2data_snoop_valid && !busy_snp) busy_snp = 1'b1;
            if (bus_tx_valid && bus_tx_ready) begin
                logic [64:0] e;
                bit          have;
                have = 1'b1;
                if (!in_pkt) begin
                    cur_snp = bus_tx_data[HDR_RESP_BIT];
                    order_log.push_back(cur_snp);
                end
                if (cur_snp && exp_snp_q.size() > 0) e = exp_snp_q.pop_front();
                else if (!cur_snp && exp_req_q.size() > 0) e = exp_req_q.pop_front();
                else have = 1'b0;
                if (!have) begin
                    checks++; errors++;
                    $display("FAIL unexpected_flit: got %h expected none", bus_tx_data);
                end else begin
                    chk(in_pkt ? "data_flit" : "hdr_flit", {bus_tx_last, bus_tx_data}, e);
                    if (!in_pkt) begin
                        rem    = e[0] ? 8 : 0;
                        in_pkt = (rem != 0);
                    end else begin
                        rem--;
                        in_pkt = (rem != 0);
                    end
                    if (!in_pkt) begin
                        lastacc_prev = 1'b1;
                        if (cur_snp) busy_snp = 1'b0;
                        else busy_req = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        logic o0, o1;
        rst = 1'b1;
        l2data_req_valid = 1'b0; l2data_req_noinv = 1'b0; l2data_req_cmd = 3'd0;
        l2data_req_addr = 26'd0; l2data_req_data = 64'd0;
        l2data_snoop_valid = 1'b0; l2data_snoop_tag = 5'd0;
        l2data_snoop_addr = 26'd0; l2data_snoop_data = 64'd0;
        bus_tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // Flush with gaps
        for (int i = 0; i < 8; i++) req_data_a[i] = 64'(i);
        drive_req(CMD_FLUSH, 1'b0, 26'h123456, 2);
        wait_drain(300);

        // Single-beat read with noinv
        drive_req(CMD_BUSRD, 1'b1, 26'h2ABCDE, 0);
        wait_drain(300);

        // Snoop and flush complete in the same cycle
        order_log.delete();
        for (int i = 0; i < 8; i++) begin
            req_data_a[i] = 64'hF100_0000_0000_0000 + 64'(i);
            snp_data_a[i] = 64'h5A00_0000_0000_0000 + 64'(i);
        end
        fork
            drive_req(CMD_FLUSH, 1'b0, 26'h0111111, 0);
            drive_snp(5'h1A, 26'h0222222, 0);
        join
        wait_drain(300);
        o0 = (order_log.size() > 0) ? order_log[0] : 1'bx;
        o1 = (order_log.size() > 1) ? order_log[1] : 1'bx;
        chk("prio_first_snoop", o0, 1'b1);
        chk("prio_second_req", o1, 1'b0);

        // Backpressure mid-DATA at idx 3
        for (int i = 0; i < 8; i++) req_data_a[i] = 64'hC0DE_0000_0000_0000 + 64'(i);
        drive_req(CMD_FLUSH, 1'b0, 26'h0333333, 1);
        wait_flit(req_data_a[3], "stall_reach");
        bus_tx_ready = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
        end
        chk("stall_data", bus_tx_data, req_data_a[3]);
        bus_tx_ready = 1'b1;
        wait_drain(300);

        // Reset mid-DATA at idx 5, then a clean flush
        for (int i = 0; i < 8; i++) req_data_a[i] = 64'hBEEF_0000_0000_0000 + 64'(i);
        drive_req(CMD_FLUSH, 1'b0, 26'h0444444, 0);
        wait_flit(req_data_a[5], "rst_reach");
        #1;
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) req_data_a[i] = 64'h5100_0000_0000_0000 + 64'(i);
        drive_req(CMD_FLUSH, 1'b0, 26'h0555555, 1);
        wait_drain(300);

        // Snoop fills while a request packet transmits
        order_log.delete();
        for (int i = 0; i < 8; i++) begin
            req_data_a[i] = 64'h6600_0000_0000_0000 + 64'(i);
            snp_data_a[i] = 64'h7700_0000_0000_0000 + 64'(i);
        end
        fork
            drive_req(CMD_FLUSH, 1'b0, 26'h0666666, 0);
            begin
                int t;
                t = 0;
                while (!bus_tx_valid && t < 300) begin
                    @(posedge clk); #1; t++;
                end
                chk("req_hdr_seen", (t >= 300), 1'b0);
                drive_snp(5'h05, 26'h0777777, 1);
            end
        join
        wait_drain(400);
        o0 = (order_log.size() > 0) ? order_log[0] : 1'bx;
        o1 = (order_log.size() > 1) ? order_log[1] : 1'bx;
        chk("order_req_first", o0, 1'b0);
        chk("order_snp_second", o1, 1'b1);

        // Random traffic on both streams with random backpressure
        rdy_rand = 1'b1;
        fork
            begin
                for (int k = 0; k < 25; k++) begin
                    logic [2:0] c;
                    c = $urandom_range(0, 1) ? 3'(CMD_FLUSH) : 3'($urandom_range(0, 2));
                    for (int i = 0; i < 8; i++) req_data_a[i] = {$urandom, $urandom};
                    drive_req(c, 1'($urandom_range(0, 1)), 26'($urandom), 3);
                    repeat ($urandom_range(0, 4)) begin
                        @(posedge clk); #1;
                    end
                end
            end
            begin
                for (int k = 0; k < 25; k++) begin
                    for (int i = 0; i < 8; i++) snp_data_a[i] = {$urandom, $urandom};
                    drive_snp(5'($urandom), 26'($urandom), 3);
                    repeat ($urandom_range(0, 6)) begin
                        @(posedge clk); #1;
                    end
                end
            end
        join
        wait_drain(5000);
        rdy_rand = 1'b0;
        bus_tx_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/l2trans_tx.md
Name: l2trans_tx

Overview:
- Transmit half of the L2 transaction unit: the receiving end of the l2data request and snoop-data streams.
- Captures each outgoing L2 command and its 8-beat line data (flush writebacks, snoop data responses) into per-stream line buffers.
- Serializes them as header+data packets onto the system bus transmit port.
- Snoop responses take priority over L2-originated requests, matching l2data's issue priority.

Parameters:
- NODE_ID, 0, 2-bit source node number placed in every packet header.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- l2data_req_valid  in  1  request beat valid
- l2data_req_noinv  in  1  no-invalidate qualifier
- l2data_req_cmd  in  3  bus command (package CMD_* encoding)
- l2data_req_addr  in  26  line address [31:6]
- l2data_req_data  in  64  beat data (meaningful only for CMD_FLUSH)
- l2trans_l2data_req_ready  out  1  request stream may start a new transaction
- l2data_snoop_valid  in  1  snoop data beat valid
- l2data_snoop_tag  in  5  snoop transaction tag
- l2data_snoop_addr  in  26  line address [31:6]
- l2data_snoop_data  in  64  beat data
- l2trans_l2data_snoop_ready  out  1  snoop stream may start a new response
- bus_tx_valid  out  1  flit valid
- bus_tx_data  out  64  flit payload
- bus_tx_last  out  1  final flit of packet
- bus_tx_ready  in  1  bus accepts flit
- l2trans_tx_idle  out  1  both buffers empty and no packet in flight

Behaviour:
- Stream protocol (both streams):
  - ready is sampled only on the first beat.
  - Once a first beat is accepted (valid & ready), every later valid cycle is accepted unconditionally, whatever ready is, until the transaction completes.
  - Beats need not be contiguous.
- Request stream:
  - cmd/noinv/addr are captured on the first beat.
  - CMD_FLUSH: 8 beats, stored in entries 0..7 in arrival order.
  - Any other cmd: 1 beat, data discarded.
- Snoop stream: always 8 beats; tag/addr captured on the first beat.
- Buffer state per stream: EMPTY -> FILL (first beat accepted) -> FULL (last beat accepted) -> EMPTY (last flit of its packet accepted by the bus).
  - ready = (state==EMPTY).
  - A single-beat request goes EMPTY -> FULL directly.
  - ready reasserts the cycle after the last flit handshake.
- Beat counter: 3 bits per stream; wraps 7->0 on completion.
- Header flit layout:
  - [63:62] NODE_ID
  - [61:59] cmd (snoop: CMD_SNOOPRESP)
  - [58] noinv (snoop: 0)
  - [57] resp (1 = snoop)
  - [56:52] tag (request: 0)
  - [51:26] addr
  - [25:1] 0
  - [0] has_data
- Transmit FSM: IDLE, HDR, DATA.
  - IDLE: if snoop FULL pick snoop, else if req FULL pick req; go to HDR the same cycle the choice is made. bus_tx_valid is registered, so the header appears the cycle after the buffer becomes FULL.
  - HDR: bus_tx_valid=1 with the header. On accept: if has_data go to DATA with index 0, else assert last with the header and return to IDLE.
  - DATA: present entry[idx]. Advance only on bus_tx_ready. last=1 at idx 7; on its accept release the buffer and go to IDLE.
  - The selected packet is held stable (data/last/valid unchanged) while bus_tx_ready=0.
- Simultaneous events:
  - Both buffers FULL in IDLE: snoop goes first.
  - A buffer may fill while the other transmits.
  - A beat arriving in the same cycle that the same stream's buffer is released is not legal (ready was low); the buffer holds its contents.
- Minimum packet spacing: one IDLE cycle between packets.
- l2trans_tx_idle = both EMPTY & FSM==IDLE.
- Reset, asynchronous, including mid-packet:
  - FSM=IDLE, both states EMPTY, counters 0.
  - bus_tx_valid=0, bus_tx_last=0, bus_tx_data=0.
  - Both ready outputs=1, idle=1.
  - Buffer contents are not reset.

Decomposition:
- Shared package (existing bus package): CMD_* encodings including CMD_FLUSH and CMD_SNOOPRESP; header field offsets; beats-per-line constant (8).
- Sub-module l2trans_linebuf: 8x64 buffer with fill counter, EMPTY/FILL/FULL state and release input. Instantiated twice (req, snoop).

Test Plan:
- Reset then flush: req cmd=CMD_FLUSH, addr=26'h123456, data beats 64'h0..7 with gaps, bus_tx_ready=1 -> header with addr field 26'h123456 and has_data=1, then data 0..7, last on beat 7; req_ready low from first beat until the cycle after the last flit.
- Single-beat CMD_BUSRD, noinv=1 -> one header flit, has_data=0, last=1, noinv bit=1; req_ready reasserts two cycles after the beat.
- Snoop and flush complete in the same cycle -> snoop packet (resp=1, tag=5'h1A) fully sent first, one idle cycle, then flush packet.
- bus_tx_ready held low 5 cycles mid-DATA at idx 3 -> flit 3 held stable, no beat skipped or duplicated.
- rst asserted mid-DATA idx 5 -> outputs go to reset values immediately; next flush transfers correctly from beat 0.
- Snoop beats arriving while a req packet transmits -> snoop buffer fills with no loss; its packet follows the req packet.
